input_vc_buffer: RTL



---
 rtl/noc_pkg.sv | 32 +++
 rtl/vc_fifo.sv | 54 +++++
 rtl/input_vc_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit field layout, flit type encodings and framing state shared by the NoC buffer
package noc_pkg;

    localparam int FLIT_W   = 32;
    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 1;
    localparam int VCHW     = 2;
    localparam int VCH_LSB  = 2;
    localparam int VCH_MSB  = 3;
    localparam int DSTX_LSB = 4;
    localparam int DSTX_MSB = 7;
    localparam int DSTY_LSB = 8;
    localparam int DSTY_MSB = 11;
    localparam int ENTRY_W  = 8;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10,
        FT_HT   = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } frame_state_e;

    function automatic logic is_head(flit_type_e t);
        return (t == FT_HEAD) || (t == FT_HT);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single virtual-channel flit FIFO with occupancy count and show-ahead output
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - per-input-port VC flit buffer with credits, RC strobe and framing checks
// NOC_BUF_BYPASS_EN forwards a write to an empty, same-cycle-granted VC straight to flit_o.
module input_vc_buffer
    import noc_pkg::*;
#(
    parameter int VCH_NUM = 2,
    parameter int DEPTH   = 4,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLIT_W-1:0]  flit_i,
    input  logic               valid_i,
    output logic [VCH_NUM-1:0] credit_o,
    output logic [VCH_NUM-1:0] valid_o,
    output logic [VCH_NUM-1:0] head_o,
    input  logic [VCH_NUM-1:0] deq_i,
    output logic [FLIT_W-1:0]  flit_o,
    output logic [ENTRY_W-1:0] rc_addr_o,
    output logic [ENTRY_W-1:0] rc_vch_o,
    output logic               rc_en_o,
    output logic               err_o
);

    logic [VCHW-1:0]    wr_vch;
    flit_type_e         wr_type;
    logic               vch_ok;
    logic               deq_one;
    logic               deq_multi;
    logic [VCH_NUM-1:0] wr_hit, accept, push, pop, byp, frame_err;
    logic [VCH_NUM-1:0] empty, full, drop_full;
    logic [FLIT_W-1:0]  dout  [VCH_NUM];
    logic [CW-1:0]      count [VCH_NUM];
    frame_state_e       state_q [VCH_NUM];
    frame_state_e       state_d [VCH_NUM];
    logic [FLIT_W-1:0]  deq_flit;
    logic               deq_act;
    logic [ENTRY_W-1:0] deq_vch;
    logic [VCH_NUM-1:0] credit_q;
    logic               err_q;
    logic               err_now;

    assign wr_vch    = flit_i[VCH_MSB:VCH_LSB];
    assign wr_type   = flit_type_e'(flit_i[TYPE_MSB:TYPE_LSB]);
    assign vch_ok    = (int'(wr_vch) < VCH_NUM);
    assign deq_one   = $onehot(deq_i);
    assign deq_multi = !$onehot0(deq_i);

    always_comb begin
        for (int v = 0; v < VCH_NUM; v++) begin
            wr_hit[v] = valid_i && vch_ok && (int'(wr_vch) == v);
            pop[v]    = deq_one && deq_i[v] && !empty[v];
`ifdef NOC_BUF_BYPASS_EN
            byp[v]    = wr_hit[v] && (count[v] == '0) && deq_one && deq_i[v];
`else
            byp[v]    = 1'b0;
`endif
            // A full VC still takes the write when the same VC is popped this cycle.
            accept[v]    = wr_hit[v] && (!full[v] || pop[v]);
            drop_full[v] = wr_hit[v] && full[v] && !pop[v];
            push[v]      = accept[v] && !byp[v];

            state_d[v]   = state_q[v];
            frame_err[v] = 1'b0;
            if (accept[v]) begin
                if (state_q[v] == ST_IDLE) begin
                    if (wr_type == FT_HEAD) state_d[v] = ST_PKT;
                    else if (wr_type != FT_HT) frame_err[v] = 1'b1;
                end else begin
                    if (wr_type == FT_TAIL) state_d[v] = ST_IDLE;
                    else if (wr_type != FT_BODY) frame_err[v] = 1'b1;
                end
            end

            valid_o[v] = (count[v] != '0);
            head_o[v]  = !empty[v] && is_head(flit_type_e'(dout[v][TYPE_MSB:TYPE_LSB]));
`ifdef NOC_BUF_BYPASS_EN
            if (wr_hit[v] && (count[v] == '0)) begin
                valid_o[v] = 1'b1;
                head_o[v]  = is_head(wr_type);
            end
`endif
        end
    end

    always_comb begin
        deq_flit = '0;
        deq_act  = 1'b0;
        deq_vch  = '0;
        for (int v = 0; v < VCH_NUM; v++) begin
            if (pop[v] || byp[v]) begin
                deq_flit = byp[v] ? flit_i : dout[v];
                deq_act  = 1'b1;
                deq_vch  = ENTRY_W'(v);
            end
        end
    end

    assign flit_o    = deq_flit;
    assign rc_en_o   = deq_act && is_head(flit_type_e'(deq_flit[TYPE_MSB:TYPE_LSB]));
    assign rc_addr_o = rc_en_o ? ENTRY_W'(deq_flit[DSTY_MSB:DSTX_LSB]) : '0;
    assign rc_vch_o  = rc_en_o ? deq_vch : '0;
    assign credit_o  = credit_q;
    assign err_o     = err_q;

    assign err_now = (valid_i && !vch_ok) || (|drop_full) || (|frame_err) || deq_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
            err_q    <= 1'b0;
            for (int v = 0; v < VCH_NUM; v++) begin
                state_q[v] <= ST_IDLE;
            end
        end else begin
            credit_q <= pop | byp;
            if (err_now) begin
                err_q <= 1'b1;
            end
            for (int v = 0; v < VCH_NUM; v++) begin
                state_q[v] <= state_d[v];
            end
        end
    end

    for (genvar v = 0; v < VCH_NUM; v++) begin : g_vc
        vc_fifo #(
            .DEPTH (DEPTH),
            .W     (FLIT_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (flit_i),
            .dout  (dout[v]),
            .count (count[v]),
            .full  (full[v]),
            .empty (empty[v])
        );
    end

endmodule
